// File: rtl/acc4_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// acc4_seq_if : term stream, result stream and adder operand bundle -- rev 1.0
// ----------------------------------------------------------------------------
interface acc4_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, n_terms, in_valid, in_data, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, n_terms, in_valid, in_data, add_sum, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/acc4_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// acc4_seq : sequential accumulator around an external 4-bit adder -- rev 1.0
// ----------------------------------------------------------------------------
module acc4_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  acc4_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc,   acc_nxt;
  logic             ovf,   ovf_nxt;
  logic [CNT_W-1:0] cnt,   cnt_nxt;
  logic             accept;
  logic             wrapped;

  assign accept  = (state == ACC) && bus.in_valid;
  // The adder exposes no carry, so a wrap shows up as the sum falling below acc.
  assign wrapped = (bus.add_sum < acc);

  assign bus.add_a     = acc;
  assign bus.add_b     = bus.in_data;
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.n_terms != CNT_ZERO) begin
            cnt_nxt   = bus.n_terms;
            state_nxt = ACC;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACC: begin
        if (accept) begin
          acc_nxt = bus.add_sum;
          ovf_nxt = ovf | wrapped;
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc4_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_acc4_seq : directed table-driven bench for acc4_seq -- rev 1.0
// ----------------------------------------------------------------------------
module tb_acc4_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc4_seq_if #(.WIDTH(4), .CNT_W(4)) bus ();

  // Stand-in for the external ripple-carry adder.
  assign bus.add_sum = bus.add_a + bus.add_b;

  acc4_seq #(.WIDTH(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Terms are packed nibbles: t[0] is the least-significant hex digit.
  typedef struct {
    logic [3:0]        n;
    logic [15:0][3:0]  t;
    logic [3:0]        sum;
    logic              ovf;
    string             name;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.n_terms   = 4'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] model_acc;
    model_acc   = 4'd0;
    bus.start   = 1'b1;
    bus.n_terms = v.n;
    tick();
    bus.start   = 1'b0;
    chk({v.name, "_busy"}, int'(bus.busy), 1);
    for (int i = 0; i < int'(v.n); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.t[i];
      chk({v.name, "_in_ready"}, int'(bus.in_ready), 1);
      chk({v.name, "_add_a"}, int'(bus.add_a), int'(model_acc));
      chk({v.name, "_early_valid"}, int'(bus.out_valid), 0);
      tick();
      model_acc = model_acc + v.t[i];
    end
    bus.in_valid = 1'b0;
    chk({v.name, "_out_valid"}, int'(bus.out_valid), 1);
    chk({v.name, "_out_sum"}, int'(bus.out_sum), int'(v.sum));
    chk({v.name, "_out_ovf"}, int'(bus.out_ovf), int'(v.ovf));
    chk({v.name, "_done_in_ready"}, int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({v.name, "_idle_busy"}, int'(bus.busy), 0);
    chk({v.name, "_idle_valid"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{4'd3,  64'h543,              4'hC, 1'b0, "basic"};
    tbl[1]  = '{4'd2,  64'h89,               4'h1, 1'b1, "wrap"};
    tbl[2]  = '{4'd2,  64'h1F,               4'h0, 1'b1, "wrap_again"};
    tbl[3]  = '{4'd0,  64'h0,                4'h0, 1'b0, "zero_terms"};
    tbl[4]  = '{4'd1,  64'h6,                4'h6, 1'b0, "single"};
    tbl[5]  = '{4'd4,  64'hFFFF,             4'hC, 1'b1, "all_f"};
    tbl[6]  = '{4'd4,  64'h4321,             4'hA, 1'b0, "ramp"};
    tbl[7]  = '{4'd4,  64'h1248,             4'hF, 1'b0, "desc"};
    tbl[8]  = '{4'd3,  64'h000,              4'h0, 1'b0, "zeros"};
    tbl[9]  = '{4'd15, 64'h0111111111111111, 4'hF, 1'b0, "max_ones"};
    tbl[10] = '{4'd15, 64'h0222222222222222, 4'hE, 1'b1, "max_twos"};

    // Reset with random inputs on the bus.
    rst           = 1'b1;
    bus.start     = 1'($urandom_range(0, 1));
    bus.n_terms   = 4'($urandom_range(0, 15));
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.in_data   = 4'($urandom_range(0, 15));
    bus.out_ready = 1'($urandom_range(0, 1));
    tick();
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready",  int'(bus.in_ready),  0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_out_sum",   int'(bus.out_sum),   0);
    chk("rst_out_ovf",   int'(bus.out_ovf),   0);
    chk("rst_add_a",     int'(bus.add_a),     0);
    rst = 1'b0;
    idle_inputs();
    tick();
    chk("idle_hold_busy", int'(bus.busy), 0);

    for (int k = 0; k < 11; k++) begin
      run_vec(tbl[k]);
    end

    // Stalls between terms, a stray start during ACC, held result in DONE.
    bus.start   = 1'b1;
    bus.n_terms = 4'd4;
    tick();
    bus.start   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(i + 1);
      tick();
      bus.in_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          if (i == 1 && g == 0) begin
            bus.start   = 1'b1;
            bus.n_terms = 4'd1;
          end
          chk("stall_in_ready", int'(bus.in_ready), 1);
          chk("stall_no_valid", int'(bus.out_valid), 0);
          tick();
          bus.start = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd5;
    for (int c = 0; c < 5; c++) begin
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_out_sum",   int'(bus.out_sum),   10);
      chk("hold_out_ovf",   int'(bus.out_ovf),   0);
      chk("hold_in_ready",  int'(bus.in_ready),  0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall_idle_busy",  int'(bus.busy),      0);
    chk("stall_idle_valid", int'(bus.out_valid), 0);
    tick();
    chk("stall_stays_idle", int'(bus.busy), 0);

    // Reset in the middle of an accumulation.
    bus.start   = 1'b1;
    bus.n_terms = 4'd5;
    tick();
    bus.start   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd7;
      tick();
    end
    chk("mid_partial_acc", int'(bus.add_a), 14);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy",     int'(bus.busy),      0);
    chk("mid_rst_valid",    int'(bus.out_valid), 0);
    chk("mid_rst_acc",      int'(bus.add_a),     0);
    chk("mid_rst_in_ready", int'(bus.in_ready),  0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst_no_valid", int'(bus.out_valid), 0);
    end
    v = '{4'd1, 64'h6, 4'h6, 1'b0, "after_rst"};
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
